// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte streams.
// A packet holds the lock until its last byte, and the lock is released if the owner stalls too long.
//
//   state     | meaning
//   IDLE      | arbitrating; a byte may be accepted when busy is low
//   LAUNCH    | transmit strobe is high for this single cycle
//   WAIT_BUSY | waiting for the transmitter to raise busy
//   WAIT_DONE | waiting for the transmitter to drop busy
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1_000_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       transmit,
  output logic [7:0]                 TxData,
  input  logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic                       timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d, grant_q, grant_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     txdata_q, txdata_d;
  logic           transmit_q, transmit_d;
  logic           last_q, last_d;
  logic           locked_q, locked_d;
  logic           err_q, err_d;

  logic [IDW-1:0] win, sel;
  logic [7:0]     sel_data;
  logic           win_found, sel_valid, sel_last, accept;

  // Two passes give the wrap-around search: indices above rr_q first, then 0..rr_q.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (IDW'(i) > rr_q)) begin
        win_found = 1'b1;
        win       = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (IDW'(i) <= rr_q)) begin
        win_found = 1'b1;
        win       = IDW'(i);
      end
    end
  end

  always_comb begin
    sel       = locked_q ? grant_q : win;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == sel) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
    accept    = (state_q == IDLE) && !busy && sel_valid;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == sel) req_ready[i] = accept;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    txdata_d   = txdata_q;
    last_d     = last_q;
    locked_d   = locked_q;
    err_d      = err_q;
    transmit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          txdata_d   = sel_data;
          last_d     = sel_last;
          grant_d    = sel;
          locked_d   = 1'b1;
          cnt_d      = '0;
          transmit_d = 1'b1;
          state_d    = LAUNCH;
        end else if (locked_q && !sel_valid) begin
          // Owner is silent; a valid from the owner always takes precedence over expiry.
          if (cnt_q == CNT_LAST) begin
            locked_d = 1'b0;
            rr_d     = grant_q;
            err_d    = 1'b1;
            cnt_d    = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (busy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!busy) begin
          state_d = IDLE;
          if (last_q) begin
            locked_d = 1'b0;
            rr_d     = grant_q;
          end
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_q       <= IDW'(NUM_REQ - 1);
      grant_q    <= '0;
      cnt_q      <= '0;
      txdata_q   <= '0;
      transmit_q <= 1'b0;
      last_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      txdata_q   <= txdata_d;
      transmit_q <= transmit_d;
      last_q     <= last_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign transmit    = transmit_q;
  assign TxData      = txdata_q;
  assign grant_id    = grant_q;
  assign locked      = locked_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, hand-written corner sequences and a random
// phase checked against a queue-based model of the arbitration rules.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int LT    = 16;
  localparam int FRAME = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic           transmit, busy, locked, timeout_err;
  logic [7:0]     TxData;
  logic [1:0]     grant_id;
  logic           busy_m = 1'b0, busy_force = 1'b0;
  int             bcnt = 0;
  int             n_checks = 0, n_fail = 0;
  int             w;

  typedef struct { logic [N-1:0] mask; logic [7:0] dbase; int exp_win; } vec_t;
  vec_t vecs[12];

  logic [8:0] rq [N][$];
  logic [9:0] exp_q[$];

  assign busy = busy_m | busy_force;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .transmit(transmit), .TxData(TxData),
    .busy(busy), .grant_id(grant_id), .locked(locked), .timeout_err(timeout_err)
  );

  // Transmitter model: busy rises on the strobe and stays up for FRAME cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_m = 1'b0;
        bcnt   = 0;
      end else if (transmit === 1'b1) begin
        busy_m = 1'b1;
        bcnt   = FRAME;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) busy_m = 1'b0;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input logic [N-1:0] mask, input logic [N-1:0] lastm, input logic [7:0] dbase);
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = dbase ^ 8'(i);
    req_valid = mask;
    req_last  = lastm;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    busy_force = 1'b0;
    drive('0, '0, 8'h00);
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic wait_busy(input logic level, input string name);
    int n;
    n = 0;
    while (busy !== level && n < 60) begin
      cyc();
      n++;
    end
    if (busy !== level) fail_now(name);
  endtask

  // Present mask, wait for one accept, check the launch, then wait out the frame.
  task automatic do_byte(input logic [N-1:0] mask, input logic [N-1:0] lastm,
                         input logic [7:0] dbase, output int win);
    int n;
    logic [N-1:0] acc;
    win = -1;
    drive(mask, lastm, dbase);
    #1;
    acc = req_ready & req_valid;
    n = 0;
    while (acc == '0 && n < 40) begin
      cyc();
      #1;
      acc = req_ready & req_valid;
      n++;
    end
    if (acc == '0) begin
      fail_now("accept_wait");
      return;
    end
    chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
    for (int i = 0; i < N; i++) if (acc[i]) win = i;
    cyc();
    req_valid = mask & ~(N'(1) << win);
    chk("tx_pulse", 32'(transmit), 32'd1);
    chk("tx_data", 32'(TxData), 32'(dbase ^ 8'(win)));
    chk("tx_grant", 32'(grant_id), 32'(win));
    chk("locked_on_accept", 32'(locked), 32'd1);
    cyc();
    chk("tx_one_cycle", 32'(transmit), 32'd0);
    wait_busy(1'b1, "busy_rise");
    wait_busy(1'b0, "busy_fall");
  endtask

  initial begin
    vecs[0]  = '{4'b1011, 8'h10, 0};
    vecs[1]  = '{4'b1011, 8'h20, 1};
    vecs[2]  = '{4'b1011, 8'h30, 3};
    vecs[3]  = '{4'b1011, 8'h40, 0};
    vecs[4]  = '{4'b0100, 8'h50, 2};
    vecs[5]  = '{4'b1100, 8'h60, 3};
    vecs[6]  = '{4'b0001, 8'h70, 0};
    vecs[7]  = '{4'b0110, 8'h80, 1};
    vecs[8]  = '{4'b1111, 8'h90, 2};
    vecs[9]  = '{4'b0011, 8'hA0, 0};
    vecs[10] = '{4'b0001, 8'hB0, 0};
    vecs[11] = '{4'b1001, 8'hC0, 3};

    // Reset values
    reset_n = 1'b0;
    cyc();
    cyc();
    chk("rst_transmit", 32'(transmit), 32'd0);
    chk("rst_txdata", 32'(TxData), 32'h00);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Round-robin table from reset (pointer starts at NUM_REQ-1)
    foreach (vecs[k]) begin
      do_byte(vecs[k].mask, 4'b1111, vecs[k].dbase, w);
      chk("vec_winner", 32'(w), 32'(vecs[k].exp_win));
      cyc();
      chk("vec_unlocked", 32'(locked), 32'd0);
    end

    // Single byte 0xA5 from requester 2 with cycle-level timing
    do_reset();
    drive(4'b0100, 4'b0100, 8'hA5 ^ 8'h02);
    #1;
    chk("sb_ready", 32'(req_ready), 32'h4);
    cyc();
    req_valid = '0;
    chk("sb_transmit", 32'(transmit), 32'd1);
    chk("sb_txdata", 32'(TxData), 32'hA5);
    chk("sb_grant", 32'(grant_id), 32'd2);
    chk("sb_locked", 32'(locked), 32'd1);
    cyc();
    chk("sb_transmit_low", 32'(transmit), 32'd0);
    wait_busy(1'b1, "sb_busy_rise");
    wait_busy(1'b0, "sb_busy_fall");
    chk("sb_locked_until_idle", 32'(locked), 32'd1);
    cyc();
    chk("sb_unlocked", 32'(locked), 32'd0);
    chk("sb_txdata_hold", 32'(TxData), 32'hA5);
    do_byte(4'b1101, 4'b1111, 8'h01, w);
    chk("sb_rr_after_2", 32'(w), 32'd3);
    cyc();

    // Packet lock: requester 1 sends 11/22/33 while requester 0 is kept valid
    do_reset();
    do_byte(4'b0010, 4'b0000, 8'h11 ^ 8'h01, w);
    chk("pl_b0", 32'(w), 32'd1);
    do_byte(4'b0011, 4'b0001, 8'h22 ^ 8'h01, w);
    chk("pl_b1", 32'(w), 32'd1);
    do_byte(4'b0011, 4'b0011, 8'h33 ^ 8'h01, w);
    chk("pl_b2", 32'(w), 32'd1);
    do_byte(4'b0001, 4'b0001, 8'h5A, w);
    chk("pl_next", 32'(w), 32'd0);
    cyc();

    // Owner valid arrives in the same cycle the lock would expire: byte wins, no error
    do_byte(4'b0100, 4'b0000, 8'h77 ^ 8'h02, w);
    chk("rc_b0", 32'(w), 32'd2);
    repeat (LT) cyc();
    chk("rc_locked_hold", 32'(locked), 32'd1);
    drive(4'b0100, 4'b0100, 8'h78 ^ 8'h02);
    #1;
    chk("rc_ready", 32'(req_ready), 32'h4);
    do_byte(4'b0100, 4'b0100, 8'h78 ^ 8'h02, w);
    chk("rc_b1", 32'(w), 32'd2);
    chk("rc_no_err", 32'(timeout_err), 32'd0);
    cyc();
    chk("rc_unlocked", 32'(locked), 32'd0);

    // Lock timeout: requester 3 stalls mid-packet while requester 0 waits
    do_byte(4'b1000, 4'b0000, 8'h3C ^ 8'h03, w);
    chk("lt_b0", 32'(w), 32'd3);
    drive(4'b0001, 4'b0001, 8'h40);
    repeat (LT) cyc();
    chk("lt_locked_before", 32'(locked), 32'd1);
    chk("lt_err_before", 32'(timeout_err), 32'd0);
    chk("lt_blocked", 32'(req_ready), 32'd0);
    cyc();
    chk("lt_locked_after", 32'(locked), 32'd0);
    chk("lt_err_after", 32'(timeout_err), 32'd1);
    do_byte(4'b0001, 4'b0001, 8'h40, w);
    chk("lt_next", 32'(w), 32'd0);
    cyc();

    // Reset asserted during WAIT_DONE
    drive(4'b0010, 4'b0010, 8'h9A ^ 8'h01);
    #1;
    chk("rm_ready", 32'(req_ready), 32'h2);
    cyc();
    req_valid = '0;
    wait_busy(1'b1, "rm_busy_rise");
    cyc();
    cyc();
    reset_n = 1'b0;
    #1;
    chk("rm_transmit", 32'(transmit), 32'd0);
    chk("rm_txdata", 32'(TxData), 32'h00);
    chk("rm_locked", 32'(locked), 32'd0);
    chk("rm_grant", 32'(grant_id), 32'd0);
    chk("rm_err", 32'(timeout_err), 32'd0);
    cyc();
    reset_n = 1'b1;
    do_byte(4'b1111, 4'b1111, 8'hE0, w);
    chk("rm_first", 32'(w), 32'd0);
    cyc();

    // Busy guard: external busy blocks acceptance
    busy_force = 1'b1;
    drive(4'b0010, 4'b0010, 8'hB1 ^ 8'h01);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("bg_ready", 32'(req_ready), 32'd0);
      chk("bg_transmit", 32'(transmit), 32'd0);
      cyc();
    end
    busy_force = 1'b0;
    #1;
    chk("bg_ready_release", 32'(req_ready), 32'h2);
    do_byte(4'b0010, 4'b0010, 8'hB1 ^ 8'h01, w);
    chk("bg_winner", 32'(w), 32'd1);

    // Random phase against a queue model of the arbitration rules
    begin
      int total, ntx, mrr, mowner, expw, j;
      bit mlocked, done;
      bit mid [N];
      logic [N-1:0] acc;
      logic [8:0] ent;
      logic [9:0] e;
      do_reset();
      total = 0;
      ntx = 0;
      mrr = N - 1;
      mowner = 0;
      mlocked = 0;
      done = 0;
      for (int i = 0; i < N; i++) begin
        mid[i] = 0;
        for (int p = 0; p < int'($urandom_range(2, 5)); p++) begin
          int len;
          len = int'($urandom_range(1, 3));
          for (int b = 0; b < len; b++) begin
            rq[i].push_back({(b == len - 1), 8'($urandom)});
            total++;
          end
        end
      end
      for (int c = 0; c < 4000 && !done; c++) begin
        cyc();
        if (transmit === 1'b1) begin
          if (exp_q.size() == 0) begin
            fail_now("rnd_unexpected_tx");
          end else begin
            e = exp_q.pop_front();
            chk("rnd_txdata", 32'(TxData), 32'(e[7:0]));
            chk("rnd_grant", 32'(grant_id), 32'(e[9:8]));
            ntx++;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (rq[i].size() > 0) begin
            req_data[8*i +: 8] = rq[i][0][7:0];
            req_last[i]        = rq[i][0][8];
            req_valid[i]       = mid[i] ? 1'b1 : 1'($urandom_range(0, 1));
          end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
          end
        end
        #1;
        if (busy) chk("rnd_ready_busy", 32'(req_ready), 32'd0);
        if (req_ready != '0)
          chk("rnd_ready_shape", 32'(($countones(req_ready) == 1) && ((req_ready & ~req_valid) == '0)), 32'd1);
        acc = req_ready & req_valid;
        if (acc != '0) begin
          w = 0;
          for (int i = 0; i < N; i++) if (acc[i]) w = i;
          if (mlocked) begin
            expw = mowner;
          end else begin
            expw = -1;
            for (int k = 1; k <= N; k++) begin
              j = (mrr + k) % N;
              if (expw < 0 && req_valid[j]) expw = j;
            end
          end
          chk("rnd_winner", 32'(w), 32'(expw));
          ent = rq[w].pop_front();
          exp_q.push_back({2'(w), ent[7:0]});
          mid[w]  = !ent[8];
          mlocked = !ent[8];
          mowner  = w;
          if (ent[8]) mrr = w;
        end
        done = (exp_q.size() == 0) && !busy && !transmit;
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) done = 0;
      end
      if (!done) fail_now("rnd_drain");
      chk("rnd_byte_count", 32'(ntx), 32'(total));
      chk("rnd_no_timeout", 32'(timeout_err), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
